// File: rtl/ercm8_5_approx_mult.sv
// ============================================================================
// Module   : ercm8_5_approx_mult
// Brief    : 8x8 unsigned error-configurable approximate multiplier. Each mask
//            bit OR-compresses one low partial-product column (0..6); the
//            16-bit product is registered. Define ERCM_INPUT_REG_EN to add an
//            input register stage (2-cycle latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ercm8_5_approx_mult (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  dat_in_a,
  input  logic [7:0]  dat_in_b,
  input  logic [6:0]  mask,
  output logic [15:0] dat_o
);

  localparam int C_OP_W   = 8;
  localparam int C_NCOL   = 2 * C_OP_W - 1;
  localparam int C_MASK_W = 7;

  logic [C_OP_W-1:0]   w_op_a;
  logic [C_OP_W-1:0]   w_op_b;
  logic [C_MASK_W-1:0] w_op_mask;

`ifdef ERCM_INPUT_REG_EN
  logic [C_OP_W-1:0]   r_a;
  logic [C_OP_W-1:0]   r_b;
  logic [C_MASK_W-1:0] r_mask;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mask <= '0;
    end else begin
      r_a    <= dat_in_a;
      r_b    <= dat_in_b;
      r_mask <= mask;
    end
  end

  assign w_op_a    = r_a;
  assign w_op_b    = r_b;
  assign w_op_mask = r_mask;
`else
  assign w_op_a    = dat_in_a;
  assign w_op_b    = dat_in_b;
  assign w_op_mask = mask;
`endif

  // Row j of the partial-product matrix: bit k has weight 2^(j+k).
  logic [C_OP_W-1:0] w_pp [C_OP_W];

  generate
    for (genvar j = 0; j < C_OP_W; j++) begin : g_row
      assign w_pp[j] = w_op_b & {C_OP_W{w_op_a[j]}};
    end
  endgenerate

  logic [3:0]        w_cnt [C_NCOL];
  logic [C_NCOL-1:0] w_or;
  logic [C_NCOL-1:0] w_col_mask;
  logic [3:0]        w_col_val;
  logic [15:0]       w_sum;

  // Weighted column sum: masked columns contribute only their OR, so they
  // neither create nor absorb carries; the max result 65025 fits 16 bits.
  always_comb begin
    w_col_mask = {{(C_NCOL - C_MASK_W){1'b0}}, w_op_mask};
    w_col_val  = '0;
    w_sum      = '0;
    for (int c = 0; c < C_NCOL; c++) begin
      w_cnt[c] = '0;
      w_or[c]  = 1'b0;
    end
    for (int j = 0; j < C_OP_W; j++) begin
      for (int k = 0; k < C_OP_W; k++) begin
        w_cnt[j+k] = w_cnt[j+k] + 4'(w_pp[j][k]);
        w_or[j+k]  = w_or[j+k] | w_pp[j][k];
      end
    end
    for (int c = 0; c < C_NCOL; c++) begin
      w_col_val = w_col_mask[c] ? {3'b000, w_or[c]} : w_cnt[c];
      w_sum     = w_sum + (16'(w_col_val) << c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dat_o <= '0;
    end else begin
      dat_o <= w_sum;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ercm8_5_approx_mult.sv
// ============================================================================
// Module   : tb_ercm8_5_approx_mult
// Brief    : Self-checking bench for ercm8_5_approx_mult (vector table, reset
//            sequences, random streams against a reference model).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ercm8_5_approx_mult;

`ifdef ERCM_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  dat_in_a;
  logic [7:0]  dat_in_b;
  logic [6:0]  mask;
  logic [15:0] dat_o;

  int n_checks;
  int n_errors;

  ercm8_5_approx_mult dut (
    .clk      (clk),
    .rst      (rst),
    .dat_in_a (dat_in_a),
    .dat_in_b (dat_in_b),
    .mask     (mask),
    .dat_o    (dat_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product minus, for each masked column, the ones lost
  // by collapsing that column's population count to a single OR bit.
  function automatic int ref_model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [6:0] m);
    int result;
    int cnt;
    result = int'(a) * int'(b);
    for (int c = 0; c < 7; c++) begin
      if (m[c]) begin
        cnt = 0;
        for (int j = 0; j <= c; j++) begin
          if (a[j] && b[c-j]) cnt++;
        end
        if (cnt > 1) result -= (cnt - 1) * (1 << c);
      end
    end
    return result;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input int exp);
    n_checks++;
    if (act !== 16'(exp)) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_le(input string name, input logic [15:0] act, input int bound);
    n_checks++;
    if (int'(act) > bound) begin
      n_errors++;
      $display("FAIL %s: got %0d above bound %0d", name, act, bound);
    end
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [6:0]  m;
    int          exp;
  } vec_t;

  vec_t vecs [8];

  // Back-to-back streaming: drive new operands every cycle, compare each
  // output against the expectation queued LAT cycles earlier.
  int exp_q[$];
  int bound_q[$];

  task automatic stream_step(input logic [7:0] a, input logic [7:0] b,
                             input logic [6:0] m, input string name);
    @(posedge clk);
    #1;
    if (exp_q.size() == LAT) begin
      check(name, dat_o, exp_q.pop_front());
      check_le({name, "_le_exact"}, dat_o, bound_q.pop_front());
    end
    dat_in_a = a;
    dat_in_b = b;
    mask     = m;
    exp_q.push_back(ref_model(a, b, m));
    bound_q.push_back(int'(a) * int'(b));
  endtask

  task automatic stream_drain(input string name);
    while (exp_q.size() > 0) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == LAT) begin
        check(name, dat_o, exp_q.pop_front());
        check_le({name, "_le_exact"}, dat_o, bound_q.pop_front());
      end else begin
        exp_q.push_back(exp_q[exp_q.size()-1]);
        bound_q.push_back(bound_q[bound_q.size()-1]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b0;
    dat_in_a = 8'h00;
    dat_in_b = 8'h00;
    mask     = 7'h00;

    vecs[0] = '{8'hFF, 8'hFF, 7'h7F, 64383};
    vecs[1] = '{8'h01, 8'hFF, 7'h7F, 255};
    vecs[2] = '{8'h03, 8'h03, 7'h02, 7};
    vecs[3] = '{8'h03, 8'h03, 7'h01, 9};
    vecs[4] = '{8'h03, 8'h03, 7'h00, 9};
    vecs[5] = '{8'hFF, 8'hFF, 7'h00, 65025};
    vecs[6] = '{8'h00, 8'hFF, 7'h7F, 0};
    vecs[7] = '{8'hFF, 8'h01, 7'h7F, 255};

    // Asynchronous reset with full-scale operands present.
    #1;
    dat_in_a = 8'hFF;
    dat_in_b = 8'hFF;
    mask     = 7'h00;
    rst      = 1'b1;
    #1;
    check("rst_async", dat_o, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_hold", dat_o, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check("rst_release_first", dat_o, 65025);

    // Directed vector table.
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      dat_in_a = vecs[i].a;
      dat_in_b = vecs[i].b;
      mask     = vecs[i].m;
      repeat (LAT) @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), dat_o, vecs[i].exp);
      check($sformatf("vec%0d_model", i), dat_o,
            ref_model(vecs[i].a, vecs[i].b, vecs[i].m));
    end

    // Reset mid-stream discards the in-flight result.
    @(posedge clk);
    #1;
    dat_in_a = 8'hFF;
    dat_in_b = 8'hFF;
    mask     = 7'h00;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_midstream", dat_o, 0);
    @(posedge clk);
    #1;
    check("rst_midstream_hold", dat_o, 0);
    @(negedge clk);
    dat_in_a = 8'h02;
    dat_in_b = 8'h03;
    rst      = 1'b0;
    repeat (LAT) @(posedge clk);
    #1;
    check("rst_midstream_resume", dat_o, 6);

    // Exact mode, random operands.
    for (int i = 0; i < 10000; i++) begin
      stream_step(8'($urandom), 8'($urandom), 7'h00, "exact_rand");
    end
    stream_drain("exact_rand");

    // Every mask value with random operands.
    for (int m = 0; m < 128; m++) begin
      for (int i = 0; i < 150; i++) begin
        stream_step(8'($urandom), 8'($urandom), 7'(m), "mask_sweep");
      end
    end
    stream_drain("mask_sweep");

    // Operands and mask all changing every cycle.
    for (int i = 0; i < 3000; i++) begin
      stream_step(8'($urandom), 8'($urandom), 7'($urandom), "b2b_rand");
    end
    stream_drain("b2b_rand");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
